// File: rtl/modular_square_result_reducer_if.sv
// Handshake bundle for the modular-square result reducer: operand pair in,
// canonical residue out.
interface modular_square_result_reducer_if #(
  parameter int MOD_LEN = 1024
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MOD_LEN+34:0]  sqa_in;
  logic [MOD_LEN+34:0]  sqb_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [MOD_LEN-1:0]   result;
  logic                 busy;

  modport slave (
    input  in_valid, sqa_in, sqb_in, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, sqa_in, sqb_in, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/modular_square_result_reducer.sv
// Folds the iterator's redundant pair (sqa, sqb) into (sqa+sqb) mod MODULUS:
// chunked carry-propagate add, then 37 restoring shift-subtract steps.
module modular_square_result_reducer #(
  parameter int                 MOD_LEN = 1024,
  parameter logic [MOD_LEN-1:0] MODULUS = {1'b1, {(MOD_LEN-2){1'b0}}, 1'b1},
  parameter int                 CHUNK   = 64
) (
  input  logic clk,
  input  logic reset_n,
  modular_square_result_reducer_if.slave bus
);
  localparam int W         = MOD_LEN + 36;
  localparam int NCH       = (W + CHUNK - 1) / CHUNK;
  localparam int PW        = NCH * CHUNK;
  localparam int RED_STEPS = 37;
  localparam int CMAX      = (NCH > RED_STEPS) ? NCH : RED_STEPS;
  localparam int CW        = $clog2(CMAX + 1);

  if (MODULUS[MOD_LEN-1] != 1'b1) begin : g_bad_modulus
    $error("MODULUS must have its top bit set");
  end

  typedef enum logic [1:0] {IDLE, ADD, REDUCE, DONE} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      a_q, b_q, s_q, msh_q, s_next;
  logic [PW:0]        diff;
  logic               carry_q, carry_n;
  logic [CHUNK-1:0]   chunk_sum;
  logic [CW-1:0]      cnt_q;
  logic [MOD_LEN-1:0] result_q;
  logic               add_last, red_last;

  assign add_last = (cnt_q == CW'(NCH - 1));
  assign red_last = (cnt_q == '0);

  // Operands shift down one chunk per ADD cycle, so the adder always sees bit 0.
  assign {carry_n, chunk_sum} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, carry_q};

  // msh_q holds MODULUS<<k; a borrow means S < MODULUS<<k and S is kept.
  assign diff   = {1'b0, s_q} - {1'b0, msh_q};
  assign s_next = diff[PW] ? s_q : diff[PW-1:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_n = ADD;
      ADD:     if (add_last) state_n = REDUCE;
      REDUCE:  if (red_last) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      msh_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          a_q     <= PW'(bus.sqa_in);
          b_q     <= PW'(bus.sqb_in);
          carry_q <= 1'b0;
          cnt_q   <= '0;
        end
        ADD: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          s_q     <= {chunk_sum, s_q[PW-1:CHUNK]};
          carry_q <= carry_n;
          if (add_last) begin
            cnt_q <= CW'(RED_STEPS - 1);
            msh_q <= PW'({MODULUS, 36'b0});
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        REDUCE: begin
          s_q   <= s_next;
          msh_q <= msh_q >> 1;
          cnt_q <= cnt_q - CW'(1);
          if (red_last) result_q <= s_next[MOD_LEN-1:0];
        end
        default: ;
      endcase
    end
  end

  // Two (MOD_LEN+35)-bit operands cannot overflow MOD_LEN+36 bits.
  always_ff @(posedge clk)
    if (reset_n && state == ADD && add_last)
      assert (!carry_n) else $error("final carry out of the add is nonzero");

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
endmodule
